// File: rtl/freq_meter_bcd_pkg.sv
// Shared types and helpers for the BCD frequency meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the FSM state enum, the gate-select encodings and the function that
// turns a clock frequency and gate select into a gate length in cycles.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic GATE_SEL_1S    = 1'b0;
  localparam logic GATE_SEL_100MS = 1'b1;

  // A 1 s window is clk_fre cycles, a 0.1 s window is a tenth of that.
  function automatic int unsigned gate_cycles(input int unsigned clk_fre, input logic sel);
    return (sel == GATE_SEL_100MS) ? (clk_fre / 10) : clk_fre;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One BCD decade of the working counter.
// Latency: q updates on the clock after inc/clr; q_nxt and carry are combinational.
// Backpressure: none; sat freezes the decade when the whole counter is full.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one to this decade this cycle
//   clr        : force the decade to zero (wins over inc)
//   sat        : whole counter is at its maximum; hold the value instead of wrapping
//   q          : current decade value (0..9)
//   q_nxt      : value q takes on the next clock
//   carry      : q == 9 while incrementing, feeds the next decade
module bcd_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic       sat,
  output logic [3:0] q,
  output logic [3:0] q_nxt,
  output logic       carry
);

  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = 4'd0;
    end else if (inc && !sat) begin
      q_nxt = (q == 4'd9) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry = (q == 4'd9) && inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated edge counter: counts sig_in rising edges over a 1 s / 0.1 s window, shows the result as packed BCD.
// Latency: result and valid appear 1 cycle after the last gate cycle; edge detect 1 cycle (3 with FREQ_SYNC_EN).
// Backpressure: none; the result is held stable through HOLD and the next gate, valid is a 1-cycle pulse.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig_in     : signal under test
//   en         : level enable; dropping it mid-gate aborts without a result
//   gate_sel   : 0 = 1 s gate (Hz), 1 = 0.1 s gate (10 Hz units); sampled when a gate starts
//   bcd        : last completed count, digit 0 in [3:0]
//   range      : gate_sel used for bcd
//   ovf        : last count saturated at all nines
//   valid      : one-cycle pulse when bcd/range/ovf update
//   busy       : high while the gate window is open
//
// Build option: define FREQ_SYNC_EN to pass sig_in through a 2-flop
// synchroniser (needed when sig_in comes from a pin); leave it undefined only
// when sig_in is generated in the clk domain.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int CLK_FRE  = 12_000_000,
  parameter int DIGITS   = 4,
  parameter int HOLD_CYC = 24_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_in,
  input  logic                  en,
  input  logic                  gate_sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  range,
  output logic                  ovf,
  output logic                  valid,
  output logic                  busy
);

  localparam int GW = $clog2(CLK_FRE);
  localparam int HW = $clog2(HOLD_CYC + 1);

  localparam logic [GW-1:0] LAST_1S    = GW'(gate_cycles(CLK_FRE, GATE_SEL_1S) - 1);
  localparam logic [GW-1:0] LAST_100MS = GW'(gate_cycles(CLK_FRE, GATE_SEL_100MS) - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);

  state_t              state;
  logic                gate_r;
  logic [GW-1:0]       gate_cnt;
  logic [HW-1:0]       hold_cnt;
  logic                wrk_ovf;
  logic                gate_last;
  logic                sig_rise;
  logic                cnt_inc;
  logic                clr;
  logic                sat;
  logic [DIGITS-1:0]   nines;
  logic [DIGITS-1:0]   dig_inc;
  logic [DIGITS-1:0]   carry;
  logic [4*DIGITS-1:0] wrk_q;
  logic [4*DIGITS-1:0] wrk_nxt;

  // ---------------------------------------------------------------- edge detect
`ifdef FREQ_SYNC_EN
  logic sync1, sync2, sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sig_q <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sig_q <= sync2;
    end
  end

  assign sig_rise = sync2 & ~sig_q;
`else
  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign sig_rise = sig_in & ~sig_q;
`endif

  // ---------------------------------------------------------- working counter
  // Cleared whenever the gate is closed, so every gate starts from zero.
  assign clr     = (state != GATE);
  assign cnt_inc = (state == GATE) & sig_rise;

  // Each decade's increment is derived from the registered nines flags rather
  // than chained through the previous decade's carry, keeping the ripple flat.
  // All carries high means every decade is 9 and an edge arrived: saturate.
  assign sat = &carry;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [DIGITS-1:0] LOW = DIGITS'((64'd1 << i) - 64'd1);

    assign nines[i]   = (wrk_q[4*i +: 4] == 4'd9);
    assign dig_inc[i] = cnt_inc & (&(nines | ~LOW));

    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (dig_inc[i]),
      .clr   (clr),
      .sat   (sat),
      .q     (wrk_q[4*i +: 4]),
      .q_nxt (wrk_nxt[4*i +: 4]),
      .carry (carry[i])
    );
  end

  // ----------------------------------------------------------------------- FSM
  assign gate_last = (gate_cnt == ((gate_r == GATE_SEL_100MS) ? LAST_100MS : LAST_1S));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_r   <= GATE_SEL_1S;
      gate_cnt <= '0;
      hold_cnt <= '0;
      wrk_ovf  <= 1'b0;
      bcd      <= '0;
      range    <= 1'b0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state    <= GATE;
            gate_r   <= gate_sel;
            gate_cnt <= '0;
            wrk_ovf  <= 1'b0;
            busy     <= 1'b1;
          end
        end

        GATE: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gate_last) begin
            // Publish the post-update count so an edge on this cycle is included.
            state    <= HOLD;
            hold_cnt <= '0;
            busy     <= 1'b0;
            bcd      <= wrk_nxt;
            range    <= gate_r;
            ovf      <= wrk_ovf | sat;
            valid    <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            wrk_ovf  <= wrk_ovf | sat;
          end
        end

        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            if (en) begin
              state    <= GATE;
              gate_r   <= gate_sel;
              gate_cnt <= '0;
              wrk_ovf  <= 1'b0;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Self-checking bench for freq_meter_bcd: directed scenarios plus randomized
// signal periods and gate selects, checked against a cycle-level edge-count
// model built from the observed gate window.
module tb_freq_meter_bcd;

  localparam int CLK_FRE  = 1000;
  localparam int DIGITS   = 2;
  localparam int HOLD_CYC = 50;
  localparam int G1S      = CLK_FRE;
  localparam int G100     = CLK_FRE / 10;
  localparam int MAXV     = 10 ** DIGITS - 1;
`ifdef FREQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sig_in = 1'b0;
  logic                en = 1'b0;
  logic                gate_sel = 1'b0;
  logic [4*DIGITS-1:0] bcd;
  logic                range;
  logic                ovf;
  logic                valid;
  logic                busy;

  freq_meter_bcd #(
    .CLK_FRE  (CLK_FRE),
    .DIGITS   (DIGITS),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .en       (en),
    .gate_sel (gate_sel),
    .bcd      (bcd),
    .range    (range),
    .ovf      (ovf),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_err  = 0;
  int n_meas = 0;

  bit abort_req = 1'b0;
  bit gsel_rand = 1'b0;
  bit sig_force = 1'b0;
  int sig_per   = 0;
  int ph        = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (32'((v / (10 ** i)) % 10) << (4 * i));
    end
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_meas(input int budget);
    int tgt;
    int k;
    tgt = n_meas + 1;
    k = 0;
    while (n_meas < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_meas < tgt) check("meas_timeout", 32'(n_meas), 32'(tgt));
  endtask

  task automatic wait_busy(input int budget);
    int k;
    k = 0;
    while (busy !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b1) check("busy_timeout", 32'(busy), 32'd1);
  endtask

  // Signal source, applied after the stimulus writes of the same cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (gsel_rand) gate_sel = 1'($urandom_range(0, 1));
      if (sig_per == 0) begin
        sig_in = sig_force;
      end else if (sig_per == 1) begin
        sig_in = 1'($urandom_range(0, 1));
      end else begin
        ph     = (ph + 1) % sig_per;
        sig_in = (ph < sig_per / 2);
      end
    end
  end

  // Reference model: a rising edge of sig_in counts when its detection cycle
  // (LAT cycles later) falls inside the gate window; results saturate at MAXV.
  bit          busy_p, sig_p, gsel_p, run_range, have_fall, gap_ok;
  bit [2:0]    hist;
  int          run_len, edges, gap;
  logic [31:0] hb;
  bit          hr, ho;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_p = 1'b0; hist = '0; hb = '0; hr = 1'b0; ho = 1'b0;
      have_fall = 1'b0; gap_ok = 1'b0; gap = 0;
      sig_p = sig_in; gsel_p = gate_sel;
    end else begin
      hist = {hist[1:0], sig_in & ~sig_p};
      if (busy && !busy_p) begin
        if (have_fall && gap_ok) check("hold_len", 32'(gap), 32'(HOLD_CYC));
        have_fall = 1'b0;
        run_len   = 0;
        edges     = 0;
        run_range = gsel_p;
      end
      if (busy) begin
        run_len++;
        if (hist[LAT]) edges++;
      end
      if (!busy && busy_p) begin
        if (abort_req) begin
          check("abort_valid", 32'(valid), 32'd0);
          check("abort_bcd", 32'(bcd), hb);
        end else begin
          hb = to_bcd((edges > MAXV) ? MAXV : edges);
          ho = (edges > MAXV);
          hr = run_range;
          check("gate_len", 32'(run_len), 32'(run_range ? G100 : G1S));
          check("valid_pulse", 32'(valid), 32'd1);
          check("bcd", 32'(bcd), hb);
          check("ovf", 32'(ovf), 32'(ho));
          check("range", 32'(range), 32'(hr));
          n_meas++;
          have_fall = 1'b1;
          gap       = 1;
          gap_ok    = en;
        end
      end else begin
        check("valid_quiet", 32'(valid), 32'd0);
        if (!busy) begin
          gap++;
          if (!en) gap_ok = 1'b0;
        end
      end
      busy_p = busy;
      sig_p  = sig_in;
      gsel_p = gate_sel;
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_range", 32'(range), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // 0.1 s gate, period 10 -> 10 edges
    gate_sel = 1'b1;
    sig_per  = 10;
    en       = 1'b1;
    tick(1);
    check("start_busy", 32'(busy), 32'd1);
    wait_meas(2500);
    check("p10_100ms_bcd", 32'(bcd), 32'h10);
    check("p10_100ms_range", 32'(range), 32'd1);

    // 1 s gate, period 2 -> 500 edges, saturates
    gate_sel = 1'b0;
    sig_per  = 2;
    wait_meas(2500);
    check("p2_sat_bcd", 32'(bcd), 32'h99);
    check("p2_sat_ovf", 32'(ovf), 32'd1);

    // period 20 -> 50 edges; gate_sel toggled mid-gate must be ignored
    sig_per = 20;
    wait_busy(200);
    tick(300);
    gate_sel = 1'b1;
    wait_meas(2500);
    check("p20_bcd", 32'(bcd), 32'h50);
    check("p20_ovf", 32'(ovf), 32'd0);
    check("p20_range", 32'(range), 32'd0);

    // Abort at gate cycle 400: result held, no valid, back to IDLE
    gate_sel = 1'b0;
    sig_per  = 10;
    wait_busy(200);
    tick(400);
    abort_req = 1'b1;
    en        = 1'b0;
    tick(5);
    check("abort_hold_bcd", 32'(bcd), 32'h50);
    check("abort_busy", 32'(busy), 32'd0);
    abort_req = 1'b0;
    en        = 1'b1;
    tick(1);
    check("restart_from_idle", 32'(busy), 32'd1);
    wait_meas(2500);
    check("p10_1s_bcd", 32'(bcd), 32'h99);
    check("p10_1s_ovf", 32'(ovf), 32'd1);

    // Asynchronous reset in the middle of a gate
    sig_per   = 0;
    sig_force = 1'b0;
    gate_sel  = 1'b1;
    wait_busy(200);
    tick(50);
    rst_n = 1'b0;
    #2;
    check("arst_bcd", 32'(bcd), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    check("arst_range", 32'(range), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    en = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single edge detected on the last gate cycle -> counted
    en = 1'b1;
    tick(G100 - LAT);
    sig_force = 1'b1;
    wait_meas(2500);
    check("edge_last_gate", 32'(bcd), 32'h01);

    // en dropped during HOLD: HOLD completes, then IDLE
    en        = 1'b0;
    sig_force = 1'b0;
    tick(HOLD_CYC + 5);
    check("hold_then_idle", 32'(busy), 32'd0);

    // Single edge detected on the first HOLD cycle -> not counted
    en = 1'b1;
    tick(G100 + 1 - LAT);
    sig_force = 1'b1;
    wait_meas(2500);
    check("edge_first_hold", 32'(bcd), 32'h00);
    sig_force = 1'b0;

    // Randomized periods and gate selects
    gsel_rand = 1'b1;
    repeat (6) begin
      if ($urandom_range(0, 9) == 0) sig_per = 1;
      else sig_per = int'($urandom_range(2, 40));
      wait_meas(2500);
    end

    gsel_rand = 1'b0;
    en        = 1'b0;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
